// File: rtl/writeback_queue.sv
// Write-side front end for the register file: an in-order FIFO that takes up to two writes per clock
// (load first, then ALU) and drains one per clock to RegWr/RW/BusW. Optional bypass lookup: WBQ_BYPASS_EN.
module writeback_queue #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  AluValid,
    input  logic [ADDR_WIDTH-1:0] AluRd,
    input  logic [DATA_WIDTH-1:0] AluData,
    input  logic                  MemValid,
    input  logic [ADDR_WIDTH-1:0] MemRd,
    input  logic [DATA_WIDTH-1:0] MemData,
    output logic                  Stall,
    output logic                  RegWr,
    output logic [ADDR_WIDTH-1:0] RW,
    output logic [DATA_WIDTH-1:0] BusW,
    input  logic [ADDR_WIDTH-1:0] LookupReg,
    output logic                  LookupHit,
    output logic [DATA_WIDTH-1:0] LookupData
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_WIDTH-1:0] XZR = '1;

    logic [ADDR_WIDTH-1:0] entryRd   [DEPTH];
    logic [DATA_WIDTH-1:0] entryData [DEPTH];
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [CW-1:0]         count;

    logic          memEnq;
    logic          aluEnq;
    logic          deq;
    logic [PW-1:0] aluSlot;

    // Handshake: a producer's request is taken at the edge only while Stall=0; while Stall=1 the
    // producer holds its request unchanged. Stall depends only on count, never on incoming requests.
    assign Stall   = (count > CW'(DEPTH - 2));
    assign memEnq  = MemValid && !Stall && (MemRd != XZR);
    assign aluEnq  = AluValid && !Stall && (AluRd != XZR);
    assign deq     = (count != '0);
    assign aluSlot = tail + PW'(memEnq);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            RegWr <= 1'b0;
            RW    <= '0;
            BusW  <= '0;
        end else begin
            if (memEnq) begin
                entryRd[tail]   <= MemRd;
                entryData[tail] <= MemData;
            end
            if (aluEnq) begin
                entryRd[aluSlot]   <= AluRd;
                entryData[aluSlot] <= AluData;
            end
            tail  <= tail + PW'(memEnq) + PW'(aluEnq);
            count <= count + CW'(memEnq) + CW'(aluEnq) - CW'(deq);
            RegWr <= deq;
            if (deq) begin
                RW   <= entryRd[head];
                BusW <= entryData[head];
                head <= head + PW'(1);
            end
        end
    end

`ifdef WBQ_BYPASS_EN
    // Output register has lowest priority; FIFO scanned oldest to youngest so the youngest match wins.
    always_comb begin
        logic [PW-1:0] idx;
        LookupHit  = 1'b0;
        LookupData = '0;
        idx        = '0;
        if (RegWr && (RW == LookupReg)) begin
            LookupHit  = 1'b1;
            LookupData = BusW;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (entryRd[idx] == LookupReg)) begin
                LookupHit  = 1'b1;
                LookupData = entryData[idx];
            end
        end
        if (LookupReg == XZR) begin
            LookupHit  = 1'b0;
            LookupData = '0;
        end
    end
`else
    logic unusedLookup;
    assign unusedLookup = ^LookupReg;
    assign LookupHit    = 1'b0;
    assign LookupData   = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed writes, expected drain stream in a queue checked by a monitor.
module tb_writeback_queue;

    localparam int DEPTH = 4;
`ifdef WBQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic        AluValid, MemValid;
    logic [4:0]  AluRd, MemRd, LookupReg;
    logic [63:0] AluData, MemData;
    logic        Stall, RegWr, LookupHit;
    logic [4:0]  RW;
    logic [63:0] BusW, LookupData;

    logic [68:0] exp_q[$];
    int          total_cnt = 0;
    int          pass_cnt  = 0;
    int          mcount    = 0;

    writeback_queue #(.DEPTH(DEPTH), .DATA_WIDTH(64), .ADDR_WIDTH(5)) dut (
        .Clk(Clk), .Reset(Reset),
        .AluValid(AluValid), .AluRd(AluRd), .AluData(AluData),
        .MemValid(MemValid), .MemRd(MemRd), .MemData(MemData),
        .Stall(Stall), .RegWr(RegWr), .RW(RW), .BusW(BusW),
        .LookupReg(LookupReg), .LookupHit(LookupHit), .LookupData(LookupData)
    );

    // clock / reset
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: act=%0h exp=%0h", name, act, exp);
    endtask

    // monitor: every emitted write must match the head of the expected queue
    initial begin
        forever begin
            @(negedge Clk);
            if (RegWr === 1'b1) begin
                if (exp_q.size() == 0) chk("unexpected_write", {RW, BusW}, 69'h0);
                else chk("write_stream", {RW, BusW}, exp_q.pop_front());
            end
        end
    end

    // driver: called at posedge+2, consumes one clock edge; model count tracks acceptance
    task automatic cycle(input bit mv, input logic [4:0] mrd, input logic [63:0] md,
                         input bit av, input logic [4:0] ard, input logic [63:0] ad,
                         output bit accepted);
        bit st;
        int enq;
        MemValid = mv; MemRd = mrd; MemData = md;
        AluValid = av; AluRd = ard; AluData = ad;
        #1;
        st = (mcount > DEPTH - 2);
        chk("stall", {68'h0, Stall}, {68'h0, st});
        enq = 0;
        if (!st) begin
            if (mv && mrd != 5'd31) begin exp_q.push_back({mrd, md}); enq++; end
            if (av && ard != 5'd31) begin exp_q.push_back({ard, ad}); enq++; end
        end
        accepted = !st;
        @(posedge Clk);
        mcount = mcount + enq - ((mcount > 0) ? 1 : 0);
        #2;
    endtask

    task automatic send(input bit mv, input logic [4:0] mrd, input logic [63:0] md,
                        input bit av, input logic [4:0] ard, input logic [63:0] ad);
        bit acc;
        int tries;
        tries = 0;
        do begin
            cycle(mv, mrd, md, av, ard, ad, acc);
            tries++;
        end while (!acc && tries < 20);
        if (!acc) chk("send_timeout", 69'h0, 69'h1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, acc);
    endtask

    task automatic look(input logic [4:0] rd, input bit hit, input logic [63:0] data);
        LookupReg = rd;
        #1;
        chk("lookup_hit", {68'h0, LookupHit}, {68'h0, (BYP ? hit : 1'b0)});
        chk("lookup_data", {5'h0, LookupData}, {5'h0, (BYP ? data : 64'h0)});
    endtask

    task automatic out_chk(input string name, input bit wr, input logic [4:0] rd, input logic [63:0] d);
        chk(name, {4'h0, RegWr, RW, BusW}, {4'h0, wr, (wr ? rd : RW), (wr ? d : BusW)});
    endtask

    initial begin
        Reset = 1'b1;
        MemValid = 0; MemRd = 0; MemData = 0;
        AluValid = 0; AluRd = 0; AluData = 0;
        LookupReg = 5'd0;
        repeat (2) @(posedge Clk);
        #2;
        Reset = 1'b0;
        chk("reset_out", {RegWr, RW, BusW}, 70'h0);
        chk("reset_stall", {68'h0, Stall}, 69'h0);
        look(5'd0, 0, 64'h0);

        // dual request on an empty queue: load first, ALU second; two-edge latency
        send(1, 5'd2, 64'hAA, 1, 5'd3, 64'hBB);
        chk("latency_idle", {68'h0, RegWr}, 69'h0);
        idle(1);
        out_chk("first_drain", 1, 5'd2, 64'hAA);
        idle(1);
        out_chk("second_drain", 1, 5'd3, 64'hBB);
        idle(1);
        out_chk("drain_done", 0, 5'd3, 64'hBB);

        // XZR writes are dropped
        send(0, 0, 0, 1, 5'd31, 64'h55);
        idle(1);
        out_chk("xzr_dropped", 0, 5'd3, 64'hBB);
        look(5'd31, 0, 64'h0);
        idle(2);

        // fill to stall, hold under stall, wrap the pointers
        send(1, 5'd10, 64'h10, 1, 5'd11, 64'h11);
        send(1, 5'd12, 64'h12, 1, 5'd13, 64'h13);
        chk("stall_full", {68'h0, Stall}, 69'h1);
        send(1, 5'd14, 64'h14, 1, 5'd15, 64'h15);
        send(1, 5'd16, 64'h16, 0, 5'd0, 64'h0);
        idle(6);
        chk("fill_drained", exp_q.size(), 69'h0);

        // bypass: youngest pending value, then output register, then nothing
        send(0, 0, 0, 1, 5'd5, 64'h1);
        look(5'd5, 1, 64'h1);
        send(0, 0, 0, 1, 5'd5, 64'h2);
        look(5'd5, 1, 64'h2);
        idle(1);
        out_chk("bypass_outreg", 1, 5'd5, 64'h2);
        look(5'd5, 1, 64'h2);
        idle(1);
        look(5'd5, 0, 64'h0);
        idle(2);

        // reset with three entries pending; requests in the reset cycle are ignored
        send(1, 5'd20, 64'h20, 1, 5'd21, 64'h21);
        send(1, 5'd22, 64'h22, 1, 5'd23, 64'h23);
        MemValid = 1; MemRd = 5'd7; MemData = 64'h7;
        AluValid = 1; AluRd = 5'd8; AluData = 64'h8;
        Reset = 1'b1;
        @(posedge Clk);
        #2;
        Reset = 1'b0;
        mcount = 0;
        exp_q.delete();
        chk("midreset_regwr", {68'h0, RegWr}, 69'h0);
        chk("midreset_stall", {68'h0, Stall}, 69'h0);
        idle(5);
        chk("midreset_quiet", {68'h0, RegWr}, 69'h0);

        // simultaneous enqueue and dequeue keeps order
        send(1, 5'd1, 64'hC1, 0, 0, 0);
        send(1, 5'd4, 64'hC4, 1, 5'd6, 64'hC6);
        idle(5);
        chk("final_empty", exp_q.size(), 69'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
